// File: rtl/ex_mul_div_pkg.sv
// Shared opcode and state encodings for the EX-stage iterative multiply/divide unit.
package ex_mul_div_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } mdOp_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10
   } mdState_e;

   function automatic logic opIsDiv(input mdOp_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic opIsSigned(input mdOp_e op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/ex_mul_div_if.sv
// Request/result bundle between the ID/EX pipeline register and the mul/div unit.
interface ex_mul_div_if #(
   parameter int WIDTH = 32
);
   logic             flush;
   logic             startEX;
   logic [1:0]       opEX;
   logic [WIDTH-1:0] operandAEX;
   logic [WIDTH-1:0] operandBEX;
   logic [WIDTH-1:0] hiOut;
   logic [WIDTH-1:0] loOut;
   logic             busy;
   logic             done;
   logic             divByZero;
   logic             stallReq;

   modport master (
      output flush, startEX, opEX, operandAEX, operandBEX,
      input  hiOut, loOut, busy, done, divByZero, stallReq
   );

   modport slave (
      input  flush, startEX, opEX, operandAEX, operandBEX,
      output hiOut, loOut, busy, done, divByZero, stallReq
   );
endinterface

// File: rtl/ex_md_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module ex_md_step #(
   parameter int WIDTH = 32
) (
   input  logic               divMode,
   input  logic [2*WIDTH-1:0] accIn,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] accOut,
   output logic               qBit
);

   logic [WIDTH:0] addSum;
   logic [WIDTH:0] partial;
   logic [WIDTH:0] trial;

   // Multiply: {high half + carry, low half} shifts right; divide: {rem, quotient} shifts left.
   assign addSum  = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
   assign partial = accIn[2*WIDTH-1:WIDTH-1];
   assign trial   = partial - {1'b0, operand};

   always_comb begin
      qBit   = 1'b0;
      accOut = {addSum, accIn[WIDTH-1:1]};
      if (divMode) begin
         qBit   = ~trial[WIDTH];
         accOut = {(qBit ? trial[WIDTH-1:0] : partial[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_mul_div.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers; stalls the pipe while busy.
module ex_mul_div
   import ex_mul_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         resetN,
   ex_mul_div_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   mdState_e           state;
   mdState_e           stateNext;
   mdOp_e              opIn;
   logic               isDivIn;
   logic               isSignedIn;
   logic               divZeroIn;
   logic               accept;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] stepAcc;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH-1:0]   operand;
   logic               qBit;
   logic               isDivOp;
   logic               negResult;
   logic               negRem;
   logic               dzFlag;
   logic [WIDTH-1:0]   fixHi;
   logic [WIDTH-1:0]   fixLo;
   logic [WIDTH-1:0]   hiReg;
   logic [WIDTH-1:0]   loReg;
   logic               doneReg;
   logic               dzReg;

   function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v);
      return ~v + (2*WIDTH)'(1);
   endfunction

   // The most negative value maps onto itself, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic signedOp);
      return (signedOp && (v < 0)) ? negW(v) : v;
   endfunction

   assign opIn       = mdOp_e'(bus.opEX);
   assign isDivIn    = opIsDiv(opIn);
   assign isSignedIn = opIsSigned(opIn);
   assign divZeroIn  = isDivIn && (bus.operandBEX == '0);
   assign magA       = magnitude(bus.operandAEX, isSignedIn);
   assign magB       = magnitude(bus.operandBEX, isSignedIn);

   // Ignoring start while done is high keeps the finishing instruction from relaunching.
   assign accept = bus.startEX && (state == MD_IDLE) && !doneReg && !bus.flush;

   always_ff @(posedge clk) begin
      if (!resetN) state <= MD_IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         MD_IDLE: if (accept) stateNext = divZeroIn ? MD_FIX : MD_CALC;
         MD_CALC: begin
            if (bus.flush)          stateNext = MD_IDLE;
            else if (count == '0)   stateNext = MD_FIX;
         end
         MD_FIX:  stateNext = MD_IDLE;
         default: stateNext = MD_IDLE;
      endcase
   end

   ex_md_step #(.WIDTH(WIDTH)) uStep (
      .divMode (isDivOp),
      .accIn   (acc),
      .operand (operand),
      .accOut  (stepAcc),
      .qBit    (qBit)
   );

   assign accNext = {stepAcc[2*WIDTH-1:1], stepAcc[0] | qBit};

   // Datapath: divide-by-zero parks the final HI/LO image in the accumulator directly.
   always_ff @(posedge clk) begin
      if (accept) begin
         count     <= CW'(WIDTH - 1);
         isDivOp   <= isDivIn;
         dzFlag    <= divZeroIn;
         negResult <= isSignedIn && (bus.operandAEX[WIDTH-1] ^ bus.operandBEX[WIDTH-1]);
         negRem    <= isSignedIn && bus.operandAEX[WIDTH-1];
         if (divZeroIn) begin
            acc     <= {bus.operandAEX, {WIDTH{1'b1}}};
            operand <= '0;
         end else if (isDivIn) begin
            acc     <= {{WIDTH{1'b0}}, magA};
            operand <= magB;
         end else begin
            acc     <= {{WIDTH{1'b0}}, magB};
            operand <= magA;
         end
      end else if (state == MD_CALC) begin
         acc   <= accNext;
         count <= count - CW'(1);
      end
   end

   always_comb begin
      fixHi = acc[2*WIDTH-1:WIDTH];
      fixLo = acc[WIDTH-1:0];
      if (!dzFlag) begin
         if (isDivOp) begin
            if (negResult) fixLo = negW(acc[WIDTH-1:0]);
            if (negRem)    fixHi = negW(acc[2*WIDTH-1:WIDTH]);
         end else if (negResult) begin
            {fixHi, fixLo} = neg2W(acc);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         hiReg   <= '0;
         loReg   <= '0;
         doneReg <= 1'b0;
         dzReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         dzReg   <= 1'b0;
         if ((state == MD_FIX) && !bus.flush) begin
            hiReg   <= fixHi;
            loReg   <= fixLo;
            doneReg <= 1'b1;
            dzReg   <= dzFlag;
         end
      end
   end

   assign bus.hiOut     = hiReg;
   assign bus.loOut     = loReg;
   assign bus.done      = doneReg;
   assign bus.divByZero = dzReg;
   assign bus.busy      = (state != MD_IDLE);
   assign bus.stallReq  = ((state == MD_IDLE) && accept) || (state != MD_IDLE);

endmodule
